// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, default address width and the
// fetch FSM state type.
package cpu_pkg;

  localparam int          DEFAULT_ADDR_W = 8;
  localparam int          FETCH_DEPTH    = 2;
  localparam logic [31:0] NOP            = 32'd0;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetchState_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer holding an instruction word and its
// fetch address per entry; entry 0 is always the head.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [31:0]       pushData,
  input  logic [ADDR_W-1:0] pushAddr,
  input  logic              pop,
  input  logic              flush,
  output logic [31:0]       headData,
  output logic [ADDR_W-1:0] headAddr,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [31:0]       data0, data1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [1:0]        cnt;
  logic              doPush, doPop;

  assign doPop  = pop && (cnt != 2'd0);
  assign doPush = push && ((cnt != 2'd2) || doPop);

  assign headData = data0;
  assign headAddr = addr0;
  assign full     = (cnt == 2'd2);
  assign empty    = (cnt == 2'd0);
  assign count    = cnt;

  // A flush drops every entry; the fetch unit never pushes in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      data0 <= NOP;
      data1 <= NOP;
      addr0 <= '0;
      addr1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({doPush, doPop})
        2'b01: begin
          data0 <= data1;
          addr0 <= addr1;
          cnt   <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) begin
            data0 <= pushData;
            addr0 <= pushAddr;
          end else begin
            data1 <= pushData;
            addr1 <= pushAddr;
          end
          cnt <= cnt + 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            data0 <= pushData;
            addr0 <= pushAddr;
          end else begin
            data0 <= data1;
            addr0 <= addr1;
            data1 <= pushData;
            addr1 <= pushAddr;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one-cycle-latency memory reads, buffers returned
// words with their addresses and hands them to the decoder, with redirects.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imemAddr,
  output logic              imemRdEn,
  input  logic [31:0]       imemData,
  input  logic              jumpEn,
  input  logic [ADDR_W-1:0] jumpAddr,
  output logic [31:0]       rawData,
  output logic              rawValid,
  input  logic              rawReady,
  output logic [ADDR_W-1:0] pcOut
);

  fetchState_t       state, stateNext;
  logic [ADDR_W-1:0] pc, inFlightAddr;
  logic              inFlight;
  logic              issueAllowed, transfer, push, roomAhead;
  logic [2:0]        occupancy;

  logic [31:0]       headData;
  logic [ADDR_W-1:0] headAddr;
  logic              bufFull, bufEmpty;
  logic [1:0]        bufCount;

  fetch_buffer #(.ADDR_W(ADDR_W)) buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pushData (imemData),
    .pushAddr (inFlightAddr),
    .pop      (transfer),
    .flush    (jumpEn),
    .headData (headData),
    .headAddr (headAddr),
    .full     (bufFull),
    .empty    (bufEmpty),
    .count    (bufCount)
  );

  assign rawValid = !bufEmpty;
  assign rawData  = rawValid ? headData : NOP;
  assign pcOut    = rawValid ? headAddr : '0;
  assign transfer = rawValid && rawReady;

  // Reads are never issued in a jump cycle, so the only stale read is the one
  // returning during the jump itself; it is dropped here.
  assign push = inFlight && !jumpEn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    issueAllowed = 1'b0;
    case (state)
      BOOT: begin
        stateNext = RUN;
      end
      RUN: begin
        issueAllowed = 1'b1;
        if (jumpEn) stateNext = REDIRECT;
      end
      REDIRECT: begin
        issueAllowed = 1'b1;
        stateNext    = jumpEn ? REDIRECT : RUN;
      end
      default: begin
        stateNext = BOOT;
      end
    endcase
  end

  // Issue decision uses only registered state and decoder/jump inputs, never
  // imemData, so entries + in-flight after this cycle never exceed two.
  assign occupancy = {1'b0, bufCount} + {2'b00, inFlight} - {2'b00, transfer};
  assign roomAhead = !bufFull || transfer;
  assign imemRdEn  = issueAllowed && !jumpEn && roomAhead && (occupancy < 3'd2);
  assign imemAddr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      inFlight     <= 1'b0;
      inFlightAddr <= '0;
    end else begin
      inFlight <= imemRdEn;
      if (imemRdEn) inFlightAddr <= pc;
      if (jumpEn)        pc <= jumpAddr;
      else if (imemRdEn) pc <= pc + 1'b1;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imemAddr  output  ADDR_W  word address presented to instruction memory.
REQ-006 imemRdEn  output  1  read request; memory returns imemData on the next cycle.
REQ-007 imemData  input  32  instruction word, valid the cycle after imemRdEn.
REQ-008 jumpEn  input  1  redirect request, single-cycle pulse.
REQ-009 jumpAddr  input  ADDR_W  redirect target, sampled when jumpEn=1.
REQ-010 rawData  output  32  instruction delivered to the control decoder.
REQ-011 rawValid  output  1  rawData holds a real instruction.
REQ-012 rawReady  input  1  decoder accepts rawData this cycle.
REQ-013 pcOut  output  ADDR_W  fetch address of the current rawData.

Function
REQ-014 A transfer SHALL occur on a cycle with rawValid=1 and rawReady=1.
REQ-015 The block SHALL hold a 2-entry in-order instruction buffer (word plus address); rawData/pcOut SHALL come from its head.
REQ-016 When rawValid=0, rawData SHALL be 32'd0 (NOP) and pcOut SHALL be 0.
REQ-017 Issue rule: imemRdEn=1 only when buffered entries + in-flight reads - (transfer this cycle) < 2, and jumpEn=0.
REQ-018 At most one read SHALL be in flight; each issue SHALL post-increment the PC by 1.
REQ-019 PC SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-020 A returning imemData SHALL be written to the buffer tail with its issue address, unless discarded per REQ-022.
REQ-021 Latency: issue at cycle N -> rawValid no earlier than cycle N+1; sustained throughput 1 instruction/cycle with rawReady=1.
REQ-022 jumpEn=1: buffer cleared, in-flight read marked discard, PC loaded with jumpAddr; first read to jumpAddr issued the following cycle.
REQ-023 jumpEn=1 together with a transfer: the transferred instruction SHALL count as delivered; all others discarded.
REQ-024 jumpEn=1 in the same cycle a read returns: that returned word SHALL be dropped.
REQ-025 rawData/rawValid/pcOut SHALL be stable while rawValid=1 and rawReady=0.
REQ-026 FSM states: BOOT (one cycle after reset, no issue), RUN (normal issue), REDIRECT (cycle after jumpEn, discard pending, issue jumpAddr); BOOT->RUN unconditionally; RUN->REDIRECT on jumpEn; REDIRECT->RUN unless jumpEn again (stay REDIRECT, reload PC).

Reset
REQ-027 While rst_n=0: PC=RESET_PC, buffer empty, no read in flight, state BOOT, imemRdEn=0, rawValid=0, rawData=32'd0, pcOut=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions immediately.
REQ-029 First imemRdEn SHALL assert in the second cycle after rst_n rises, with imemAddr=RESET_PC.

Structure
REQ-030 Shared package cpu_pkg SHALL hold NOP (32'd0), default ADDR_W, and the fetch FSM state enum.
REQ-031 The 2-entry buffer SHALL be a sub-module fetch_buffer (push, pop, flush, full, empty, count).
REQ-032 No combinational path from imemData to imemRdEn.

Verification
REQ-033 Reset release, rawReady=1, memory word k = 32'h1C000000+k -> rawData sequence 1C000000,1C000001,... with pcOut 0,1,2..., one per cycle after start.
REQ-034 rawReady=0 for 5 cycles mid-stream -> rawValid held, rawData unchanged, imemRdEn low once 2 entries held; no word lost or duplicated on resume.
REQ-035 jumpEn with jumpAddr=8'h40 while 2 entries buffered -> next delivered pcOut=8'h40, no stale words delivered.
REQ-036 jumpEn coincident with transfer of pcOut=5 and a returning read -> pcOut=5 delivered once, returned word dropped, next pcOut=jumpAddr.
REQ-037 Start RESET_PC=8'hFE -> pcOut FE, FF, 00, 01 in order.
REQ-038 rst_n pulsed low mid-stream -> outputs zero asynchronously, fetch restarts at RESET_PC.
